// File: rtl/if_id_skid_stage_if.sv
// Valid/ready stream carrying one fetched instruction with its PC and side-band.
// The master drives the payload and valid, the slave returns ready.
interface if_id_skid_stage_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned META_W  = 2
);
  logic               valid;
  logic               ready;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic [META_W-1:0]  meta;

  modport master (output valid, output pc, output instr, output meta, input ready);
  modport slave  (input valid, input pc, input instr, input meta, output ready);
endinterface

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage: output register plus one skid entry, registered upstream
// ready, NOP bubble on an empty output, synchronous flush and a saturating
// count of entries killed by flush.
module if_id_skid_stage #(
  parameter int unsigned        PC_W       = 32,
  parameter int unsigned        INSTR_W    = 32,
  parameter int unsigned        META_W     = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(32'h0000_0013),
  parameter int unsigned        KILL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  pause,
  if_id_skid_stage_if.slave     if_bus,
  if_id_skid_stage_if.master    id_bus,
  output logic [KILL_CNT_W-1:0] kill_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [META_W-1:0]  meta;
  } entry_t;

  localparam entry_t BUBBLE = '{pc: '0, instr: NOP_INSTR, meta: '0};

  state_t                state, state_n;
  entry_t                out_q, out_n, skd_q, skd_n, in_e;
  logic                  if_ready_q;
  logic                  id_valid, accept, drain;
  logic [1:0]            held;
  logic [KILL_CNT_W:0]   kill_sum;
  logic [KILL_CNT_W-1:0] kill_n;

  // Handshake qualifiers and the incoming entry.
  always_comb begin
    in_e     = '{pc: if_bus.pc, instr: if_bus.instr, meta: if_bus.meta};
    id_valid = (state != EMPTY);
    accept   = if_bus.valid & if_ready_q;
    drain    = id_valid & id_bus.ready & ~pause;
  end

  // Next state and storage updates; flush overrides accept and drain.
  always_comb begin
    state_n = state;
    out_n   = out_q;
    skd_n   = skd_q;
    if (flush) begin
      state_n = EMPTY;
      out_n   = BUBBLE;
      skd_n   = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_n = ONE;
            out_n   = in_e;
          end
        end
        ONE: begin
          if (accept && drain) begin
            out_n = in_e;
          end else if (accept) begin
            state_n = TWO;
            skd_n   = in_e;
          end else if (drain) begin
            // Going empty: bubble the payload but leave the last PC visible.
            state_n     = EMPTY;
            out_n.instr = NOP_INSTR;
            out_n.meta  = '0;
          end
        end
        TWO: begin
          if (drain) begin
            state_n = ONE;
            out_n   = skd_q;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // Flush-kill counter: add the number of held entries, saturating at all-ones.
  always_comb begin
    unique case (state)
      ONE:     held = 2'd1;
      TWO:     held = 2'd2;
      default: held = 2'd0;
    endcase
    kill_sum = {1'b0, kill_cnt} + (KILL_CNT_W+1)'(held);
    kill_n   = kill_cnt;
    if (flush) begin
      kill_n = kill_sum[KILL_CNT_W] ? '1 : kill_sum[KILL_CNT_W-1:0];
    end
  end

  // State, storage, registered upstream ready and kill counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      out_q      <= BUBBLE;
      skd_q      <= '0;
      if_ready_q <= 1'b1;
      kill_cnt   <= '0;
    end else begin
      state      <= state_n;
      out_q      <= out_n;
      skd_q      <= skd_n;
      if_ready_q <= (state_n != TWO);
      kill_cnt   <= kill_n;
    end
  end

  assign if_bus.ready = if_ready_q;
  assign id_bus.valid = id_valid;
  assign id_bus.pc    = out_q.pc;
  assign id_bus.instr = out_q.instr;
  assign id_bus.meta  = out_q.meta;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: a default instance plus a KILL_CNT_W=2
// instance driven with identical inputs for the counter saturation case.
module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        pause = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic [1:0]  in_meta = '0;
  logic        in_id_ready = 1'b1;

  logic [7:0] kill_a;
  logic [1:0] kill_b;

  int checks = 0;
  int errors = 0;
  int exp_a  = 0;
  int exp_b  = 0;

  if_id_skid_stage_if #(.PC_W(32), .INSTR_W(32), .META_W(2)) f1 ();
  if_id_skid_stage_if #(.PC_W(32), .INSTR_W(32), .META_W(2)) d1 ();
  if_id_skid_stage_if #(.PC_W(32), .INSTR_W(32), .META_W(2)) f2 ();
  if_id_skid_stage_if #(.PC_W(32), .INSTR_W(32), .META_W(2)) d2 ();

  assign f1.valid = in_valid;
  assign f1.pc    = in_pc;
  assign f1.instr = in_instr;
  assign f1.meta  = in_meta;
  assign d1.ready = in_id_ready;
  assign f2.valid = in_valid;
  assign f2.pc    = in_pc;
  assign f2.instr = in_instr;
  assign f2.meta  = in_meta;
  assign d2.ready = in_id_ready;

  if_id_skid_stage #(.PC_W(32), .INSTR_W(32), .META_W(2), .KILL_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pause(pause),
    .if_bus(f1), .id_bus(d1), .kill_cnt(kill_a)
  );

  if_id_skid_stage #(.PC_W(32), .INSTR_W(32), .META_W(2), .KILL_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .pause(pause),
    .if_bus(f2), .id_bus(d2), .kill_cnt(kill_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  function automatic logic [1:0] meta_of(input logic [31:0] pc);
    return pc[3:2];
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins_of(pc);
    in_meta  = meta_of(pc);
  endtask

  task automatic note_flush(input int held);
    exp_a = (exp_a + held > 255) ? 255 : exp_a + held;
    exp_b = (exp_b + held > 3) ? 3 : exp_b + held;
  endtask

  // From EMPTY with pause held: two accepts leave the stage in TWO.
  task automatic fill_two(input logic [31:0] pc);
    pause = 1'b1;
    present(pc);
    cycle();
    present(pc + 32'd4);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid    = 1'($urandom);
      in_pc       = $urandom;
      in_instr    = $urandom;
      in_meta     = 2'($urandom);
      flush       = 1'($urandom);
      pause       = 1'($urandom);
      in_id_ready = 1'($urandom);
      cycle();
      checks++; if (f1.ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b expected 1", f1.ready); end
      checks++; if (d1.valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", d1.valid); end
      checks++; if (d1.instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_id_instr: got %h expected 00000013", d1.instr); end
      checks++; if (d1.pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h expected 0", d1.pc); end
      checks++; if (kill_a !== 8'd0) begin errors++; $display("FAIL reset_kill_cnt: got %0d expected 0", kill_a); end
    end
    in_valid = 1'b0; flush = 1'b0; pause = 1'b0; in_id_ready = 1'b1;
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      present(pcs[i]);
      cycle();
      checks++; if (d1.valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, d1.valid); end
      checks++; if (d1.pc !== pcs[i]) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, d1.pc, pcs[i]); end
      checks++; if (d1.instr !== ins_of(pcs[i])) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, d1.instr, ins_of(pcs[i])); end
      checks++; if (f1.ready !== 1'b1) begin errors++; $display("FAIL stream_if_ready[%0d]: got %b expected 1", i, f1.ready); end
    end
    in_valid = 1'b0;
    cycle();
    checks++; if (d1.valid !== 1'b0) begin errors++; $display("FAIL stream_empty_valid: got %b expected 0", d1.valid); end
    checks++; if (d1.instr !== 32'h0000_0013) begin errors++; $display("FAIL stream_empty_nop: got %h expected 00000013", d1.instr); end
    checks++; if (d1.meta !== 2'b00) begin errors++; $display("FAIL stream_empty_meta: got %b expected 00", d1.meta); end
    checks++; if (d1.pc !== 32'h8) begin errors++; $display("FAIL stream_empty_pc_hold: got %h expected 00000008", d1.pc); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] order [3] = '{32'h10, 32'h14, 32'h18};
    present(32'h10);
    cycle();
    pause = 1'b1;
    present(32'h14);
    cycle();
    present(32'h18);
    for (int i = 0; i < 3; i++) begin
      checks++; if (f1.ready !== 1'b0) begin errors++; $display("FAIL bp_if_ready[%0d]: got %b expected 0", i, f1.ready); end
      checks++; if (d1.pc !== 32'h10 || d1.valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got pc %h valid %b expected pc 00000010 valid 1", i, d1.pc, d1.valid); end
      checks++; if (d1.meta !== meta_of(32'h10)) begin errors++; $display("FAIL bp_meta[%0d]: got %b expected %b", i, d1.meta, meta_of(32'h10)); end
      cycle();
    end
    pause = 1'b0;
    cycle();
    checks++; if (d1.pc !== order[1]) begin errors++; $display("FAIL bp_drain_skid: got %h expected %h", d1.pc, order[1]); end
    checks++; if (f1.ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", f1.ready); end
    cycle();
    checks++; if (d1.pc !== order[2] || d1.valid !== 1'b1) begin errors++; $display("FAIL bp_drain_last: got pc %h valid %b expected pc %h valid 1", d1.pc, d1.valid, order[2]); end
    in_valid = 1'b0;
    cycle();
    checks++; if (d1.valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", d1.valid); end
  endtask

  task automatic test_flush_two();
    fill_two(32'h20);
    checks++; if (f1.ready !== 1'b0) begin errors++; $display("FAIL flush_pre_two: got if_ready %b expected 0", f1.ready); end
    flush = 1'b1;
    present(32'h40);
    cycle();
    note_flush(2);
    flush = 1'b0; pause = 1'b0; in_valid = 1'b0;
    checks++; if (d1.valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", d1.valid); end
    checks++; if (d1.instr !== 32'h0000_0013) begin errors++; $display("FAIL flush_instr: got %h expected 00000013", d1.instr); end
    checks++; if (d1.pc !== 32'h0 || d1.meta !== 2'b00) begin errors++; $display("FAIL flush_pc_meta: got pc %h meta %b expected 0 0", d1.pc, d1.meta); end
    checks++; if (f1.ready !== 1'b1) begin errors++; $display("FAIL flush_if_ready: got %b expected 1", f1.ready); end
    checks++; if (kill_a !== 8'(exp_a)) begin errors++; $display("FAIL flush_kill: got %0d expected %0d", kill_a, exp_a); end
    cycle();
    checks++; if (d1.valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b expected 0", d1.valid); end
  endtask

  task automatic test_kill_saturation();
    for (int i = 0; i < 4; i++) begin
      fill_two(32'h100 + 32'(i) * 32'h10);
      flush = 1'b1;
      cycle();
      note_flush(2);
      flush = 1'b0; pause = 1'b0;
      checks++; if (kill_b !== 2'(exp_b)) begin errors++; $display("FAIL kill_sat[%0d]: got %0d expected %0d", i, kill_b, exp_b); end
      checks++; if (kill_a !== 8'(exp_a)) begin errors++; $display("FAIL kill_wide[%0d]: got %0d expected %0d", i, kill_a, exp_a); end
    end
    flush = 1'b1;
    cycle();
    note_flush(0);
    flush = 1'b0;
    checks++; if (kill_a !== 8'(exp_a)) begin errors++; $display("FAIL kill_empty: got %0d expected %0d", kill_a, exp_a); end
    pause = 1'b1;
    present(32'h200);
    cycle();
    in_valid = 1'b0;
    flush = 1'b1;
    cycle();
    note_flush(1);
    flush = 1'b0; pause = 1'b0;
    checks++; if (kill_a !== 8'(exp_a)) begin errors++; $display("FAIL kill_one: got %0d expected %0d", kill_a, exp_a); end
    checks++; if (kill_b !== 2'(exp_b)) begin errors++; $display("FAIL kill_sat_one: got %0d expected %0d", kill_b, exp_b); end
  endtask

  task automatic test_async_reset();
    fill_two(32'h60);
    #3 rst = 1'b0;
    #1;
    exp_a = 0; exp_b = 0;
    checks++; if (d1.valid !== 1'b0 || f1.ready !== 1'b1) begin errors++; $display("FAIL areset_handshake: got valid %b ready %b expected 0 1", d1.valid, f1.ready); end
    checks++; if (d1.pc !== 32'h0 || d1.instr !== 32'h0000_0013) begin errors++; $display("FAIL areset_payload: got pc %h instr %h expected 0 00000013", d1.pc, d1.instr); end
    checks++; if (kill_a !== 8'd0) begin errors++; $display("FAIL areset_kill: got %0d expected 0", kill_a); end
    cycle();
    rst = 1'b1;
    pause = 1'b0;
    present(32'h80);
    cycle();
    checks++; if (d1.valid !== 1'b1 || d1.pc !== 32'h80) begin errors++; $display("FAIL restart_first: got valid %b pc %h expected 1 00000080", d1.valid, d1.pc); end
    present(32'h84);
    cycle();
    checks++; if (d1.pc !== 32'h84 || d1.instr !== ins_of(32'h84)) begin errors++; $display("FAIL restart_second: got pc %h instr %h expected 00000084 %h", d1.pc, d1.instr, ins_of(32'h84)); end
    in_valid = 1'b0;
    cycle();
    checks++; if (d1.valid !== 1'b0 || kill_a !== 8'd0) begin errors++; $display("FAIL restart_drain: got valid %b kill %0d expected 0 0", d1.valid, kill_a); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_two();
    test_kill_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
